// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: icode and status encodings, sequencer FSM states,
// stage_en bit positions and small decode helpers.
// Configuration macro: Y86_SINGLE_STEP_EN adds the StPause state.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam int unsigned STG_FETCH   = 0;
  localparam int unsigned STG_DECODE  = 1;
  localparam int unsigned STG_EXECUTE = 2;
  localparam int unsigned STG_MEMORY  = 3;
  localparam int unsigned STG_WB      = 4;

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StDecode,
    StExecute,
    StMemory,
    StWriteback,
    StPcUpd,
`ifdef Y86_SINGLE_STEP_EN
    StPause,
`endif
    StHalt,
    StError
  } state_e;

  // Instructions that access data memory during the MEMORY stage.
  function automatic logic is_mem_icode(input logic [3:0] icode);
    return icode inside {IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ};
  endfunction

  function automatic logic [4:0] stage_of(input state_e s);
    logic [4:0] r;
    r = '0;
    case (s)
      StFetch:     r[STG_FETCH]   = 1'b1;
      StDecode:    r[STG_DECODE]  = 1'b1;
      StExecute:   r[STG_EXECUTE] = 1'b1;
      StMemory:    r[STG_MEMORY]  = 1'b1;
      StWriteback: r[STG_WB]      = 1'b1;
      default:     r = '0;
    endcase
    return r;
  endfunction

  function automatic logic busy_of(input state_e s);
    return !(s inside {StIdle, StHalt, StError});
  endfunction

endpackage

// File: rtl/y86_seq_ctrl_if.sv
// Bus between the SEQ control sequencer and its datapath / memory side.
// master: the sequencer (drives pc, stage_en, mem_req, stat, busy, instr_cnt).
// slave:  datapath, fetch unit and data memory (drive start, fetch results,
//         cnd, valC/valP/valM, mem_ack, dmem_error).
interface y86_seq_ctrl_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned CNT_W  = 32
);
  logic              start;
  logic [3:0]        icode;
  logic              instr_valid;
  logic              imem_error;
  logic              cnd;
  logic [ADDR_W-1:0] valC;
  logic [ADDR_W-1:0] valP;
  logic [ADDR_W-1:0] valM;
  logic              mem_ack;
  logic              dmem_error;

  logic [ADDR_W-1:0] pc;
  logic [4:0]        stage_en;
  logic              mem_req;
  logic [2:0]        stat;
  logic              busy;
  logic [CNT_W-1:0]  instr_cnt;

  modport master (
    input  start, icode, instr_valid, imem_error, cnd, valC, valP, valM, mem_ack, dmem_error,
    output pc, stage_en, mem_req, stat, busy, instr_cnt
  );

  modport slave (
    output start, icode, instr_valid, imem_error, cnd, valC, valP, valM, mem_ack, dmem_error,
    input  pc, stage_en, mem_req, stat, busy, instr_cnt
  );
endinterface

// File: rtl/y86_next_pc.sv
// Combinational next-PC selection for Y86-64.
// Ports: icode, cnd (branch condition), valC, valP, valM in; new_pc out.
module y86_next_pc
  import y86_pkg::*;
#(
  parameter int unsigned ADDR_W = 64
) (
  input  logic [3:0]        icode,
  input  logic              cnd,
  input  logic [ADDR_W-1:0] valC,
  input  logic [ADDR_W-1:0] valP,
  input  logic [ADDR_W-1:0] valM,
  output logic [ADDR_W-1:0] new_pc
);

  always_comb begin
    new_pc = valP;
    case (icode)
      IJXX:    new_pc = cnd ? valC : valP;
      ICALL:   new_pc = valC;
      IRET:    new_pc = valM;
      default: new_pc = valP;
    endcase
  end

endmodule

// File: rtl/y86_seq_ctrl.sv
// Multi-cycle control sequencer for the Y86-64 SEQ processor. Owns the PC and
// steps FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and PCUPD one per cycle, with
// a variable-latency data-memory handshake and a bounded memory wait.
// Ports: clk, rst_n (async, active low), step (only with Y86_SINGLE_STEP_EN),
//        bus (y86_seq_ctrl_if.master: start, fetch results, memory handshake in;
//        pc, stage_en, mem_req, stat, busy, instr_cnt out; all outputs registered).
// Configuration macro: Y86_SINGLE_STEP_EN inserts a PAUSE state after PCUPD
// that waits for a step pulse.
module y86_seq_ctrl
  import y86_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 64,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int unsigned       CNT_W       = 32,
  parameter int unsigned       MEM_TIMEOUT = 16
) (
  input logic            clk,
  input logic            rst_n,
`ifdef Y86_SINGLE_STEP_EN
  input logic            step,
`endif
  y86_seq_ctrl_if.master bus
);

  // Wait counter only needs to reach MEM_TIMEOUT-1.
  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [2:0]          stat_q, stat_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                mem_req_q, mem_req_d;
  logic [3:0]          icode_q, icode_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [4:0]          stage_en_q;
  logic                busy_q;
  logic [ADDR_W-1:0]   new_pc;
  logic                timeout_hit;

  y86_next_pc #(
    .ADDR_W (ADDR_W)
  ) u_next_pc (
    .icode  (icode_q),
    .cnd    (bus.cnd),
    .valC   (bus.valC),
    .valP   (bus.valP),
    .valM   (bus.valM),
    .new_pc (new_pc)
  );

  if (MEM_TIMEOUT == 0) begin : g_no_timeout
    assign timeout_hit = 1'b0;
  end else begin : g_timeout
    // True in the MEM_TIMEOUT-th MEMORY cycle.
    assign timeout_hit = (wait_q == WAIT_W'(MEM_TIMEOUT - 1));
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    stat_d    = stat_q;
    cnt_d     = cnt_q;
    mem_req_d = mem_req_q;
    icode_d   = icode_q;
    wait_d    = wait_q;

    unique case (state_q)
      StIdle, StHalt, StError: begin
        if (bus.start) begin
          state_d = StFetch;
          pc_d    = RESET_PC;
          stat_d  = STAT_AOK;
          cnt_d   = '0;
        end
      end
      StFetch: begin
        icode_d = bus.icode;
        if (bus.imem_error) begin
          state_d = StError;
          stat_d  = STAT_ADR;
        end else if (!bus.instr_valid) begin
          state_d = StError;
          stat_d  = STAT_INS;
        end else if (bus.icode == IHALT) begin
          state_d = StHalt;
          stat_d  = STAT_HLT;
        end else begin
          state_d = StDecode;
        end
      end
      StDecode: state_d = StExecute;
      StExecute: begin
        state_d   = StMemory;
        wait_d    = '0;
        mem_req_d = is_mem_icode(icode_q);
      end
      StMemory: begin
        // mem_req_q is set exactly when the latched icode touches memory.
        if (!mem_req_q) begin
          state_d = StWriteback;
        end else if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          if (bus.dmem_error) begin
            state_d = StError;
            stat_d  = STAT_ADR;
          end else begin
            state_d = StWriteback;
          end
        end else if (timeout_hit) begin
          mem_req_d = 1'b0;
          state_d   = StError;
          stat_d    = STAT_ADR;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      StWriteback: state_d = StPcUpd;
      StPcUpd: begin
        pc_d  = new_pc;
        cnt_d = cnt_q + CNT_W'(1);
`ifdef Y86_SINGLE_STEP_EN
        state_d = StPause;
`else
        state_d = StFetch;
`endif
      end
`ifdef Y86_SINGLE_STEP_EN
      StPause: begin
        if (step) state_d = StFetch;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      stat_q     <= STAT_AOK;
      cnt_q      <= '0;
      mem_req_q  <= 1'b0;
      icode_q    <= INOP;
      wait_q     <= '0;
      stage_en_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      stat_q     <= stat_d;
      cnt_q      <= cnt_d;
      mem_req_q  <= mem_req_d;
      icode_q    <= icode_d;
      wait_q     <= wait_d;
      // Registered decode of the next state, so these track state_q exactly.
      stage_en_q <= stage_of(state_d);
      busy_q     <= busy_of(state_d);
    end
  end

  assign bus.pc        = pc_q;
  assign bus.stage_en  = stage_en_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.stat      = stat_q;
  assign bus.busy      = busy_q;
  assign bus.instr_cnt = cnt_q;

endmodule

// File: doc/y86_seq_ctrl.md
Name: y86_seq_ctrl

Overview:
Multi-cycle control sequencer for the Y86-64 SEQ processor. It owns the PC register and steps fetch, decode, execute, memory, writeback and PC-update one stage per cycle. It replaces free-running clock toggling and combinational PC feedback with an explicit FSM. It also adds a variable-latency data-memory handshake, architectural status reporting and parametrised address and counter widths.

Parameters:
ADDR_W, 64, width of PC, valC, valP and valM.
RESET_PC, 0, PC loaded on reset and on every start.
CNT_W, 32, width of the retired-instruction counter.
MEM_TIMEOUT, 16, maximum MEMORY-state cycles to wait for mem_ack; 0 disables the timeout.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  begin execution at RESET_PC; ignored while busy=1.
icode  in  4  from fetch.
instr_valid  in  1  from fetch.
imem_error  in  1  from fetch.
cnd  in  1  condition from execute.
valC  in  ADDR_W  constant word from fetch.
valP  in  ADDR_W  sequential next PC from fetch.
valM  in  ADDR_W  memory read data (return address for ret).
mem_ack  in  1  data-memory access complete.
dmem_error  in  1  data-memory address error, valid with mem_ack.
pc  out  ADDR_W  current PC presented to fetch.
stage_en  out  5  one-hot: [0]fetch [1]decode [2]execute [3]memory [4]writeback.
mem_req  out  1  data-memory request.
stat  out  3  AOK=1, HLT=2, ADR=3, INS=4.
busy  out  1  high in every state except IDLE, HALT and ERROR.
instr_cnt  out  CNT_W  count of retired instructions.
step  in  1  single-step advance; present only when Y86_SINGLE_STEP_EN is defined.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, pc=RESET_PC, stat=AOK, stage_en=0, mem_req=0, busy=0, instr_cnt=0.
- All outputs are registered. stage_en is decoded directly from the state register.
- IDLE: on start=1, go to FETCH; pc=RESET_PC, stat=AOK, instr_cnt=0.
- FETCH, 1 cycle:
  - imem_error=1 -> ERROR, stat=ADR.
  - else instr_valid=0 -> ERROR, stat=INS.
  - else icode=0 (halt) -> HALT, stat=HLT.
  - else -> DECODE.
  - imem_error takes priority over instr_valid.
- DECODE (1 cycle) -> EXECUTE (1 cycle) -> MEMORY.
- MEMORY:
  - Memory icodes are 4, 5, 8, 9, A and B. For these, mem_req=1 for every MEMORY cycle until mem_ack.
  - mem_ack is sampled each cycle. An ack in the first cycle gives zero wait.
  - mem_ack with dmem_error=1 -> ERROR, stat=ADR. mem_ack alone -> WRITEBACK.
  - The wait counter resets on MEMORY entry. After MEM_TIMEOUT cycles without ack -> ERROR, stat=ADR, and mem_req drops the same edge.
  - Non-memory icodes: MEMORY lasts 1 cycle with mem_req=0.
  - mem_ack and dmem_error are ignored in all other states.
- WRITEBACK, 1 cycle -> PCUPD.
- PCUPD, 1 cycle; stage_en=0. Next pc:
  - icode 7 (jXX): cnd ? valC : valP.
  - icode 8 (call): valC.
  - icode 9 (ret): valM.
  - otherwise: valP.
  - instr_cnt increments, wrapping modulo 2^CNT_W. Then -> FETCH.
- Latency: 6 cycles per non-memory instruction; 6+W for a memory instruction acked after W wait cycles.
- HALT and ERROR are terminal. pc holds the faulting or halting PC and stat holds its code. start restarts exactly as from IDLE.
- instr_cnt does not count halt or faulting instructions.
- start during busy=1 has no effect.
- Reset mid-instruction aborts immediately and clears mem_req.

Optional Feature:
Macro Y86_SINGLE_STEP_EN.
- Defined: step port exists. PCUPD goes to PAUSE instead of FETCH. PAUSE has stage_en=0 and busy=1, and leaves on a step=1 cycle to FETCH. step is ignored outside PAUSE. The first instruction after start runs without a step.
- Undefined: no step port and no PAUSE state; PCUPD goes straight to FETCH.

Decomposition:
- Shared package y86_pkg:
  - icode constants IHALT=0, INOP=1, IRRMOVQ=2, IIRMOVQ=3, IRMMOVQ=4, IMRMOVQ=5, IOPQ=6, IJXX=7, ICALL=8, IRET=9, IPUSHQ=A, IPOPQ=B.
  - Status constants STAT_AOK/HLT/ADR/INS.
  - FSM state enum and stage_en bit indices.
- One combinational sub-module, y86_next_pc (icode, cnd, valC, valP, valM -> new_pc), reused later by the pipelined design.

Test Plan:
- Reset then start; fetch model returns nop (icode=1) at 0, valP=1, then halt at 1 -> stage_en walks 1,2,4,8,16,0; pc=1; stat=2 (HLT); instr_cnt=1; busy=0.
- jXX at pc=0x10, valC=0x40, valP=0x19: cnd=1 -> pc=0x40; repeat with cnd=0 -> pc=0x19.
- mrmovq with mem_ack after 3 wait cycles -> mem_req high exactly 4 cycles; instruction total 9 cycles; valM ignored; pc=valP.
- ret with valM=0x100 and immediate ack -> pc=0x100, 6 cycles. Memory instruction never acked with MEM_TIMEOUT=16 -> ERROR, stat=3, mem_req low.
- instr_valid=0 -> stat=4; imem_error=1 with instr_valid=0 -> stat=3. start while busy ignored; rst_n pulse mid-MEMORY -> IDLE, pc=RESET_PC, mem_req=0 asynchronously.
- Y86_SINGLE_STEP_EN: after first nop the FSM holds in PAUSE with pc updated for 10 cycles; one step pulse -> next FETCH; step outside PAUSE has no effect.
